gshare_pht: RTL

// - Gshare direction predictor: owns the PHT of 2-bit counters, the speculative GHR and the architectural GHR.
// - Front side: the PC stage looks up a prediction and receives a PHT index.
//   The prediction and index then travel down the pipeline with the PC.
// - Back side: the execute stage returns the index with the resolved outcome.

---
 rtl/gshare_pht.sv | 89 ++++++++
 1 files changed

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by PC ^ GHR,
// with a speculative GHR for lookups and an architectural GHR for repair.
module gshare_pht #(
    parameter int GHR_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_pc,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic                  is_branch_taken_out,
    output logic [GHR_WIDTH-1:0]  pht_index_out,
    input  logic                  update_valid,
    input  logic                  update_is_taken,
    input  logic                  update_mispredict,
    input  logic [GHR_WIDTH-1:0]  update_pht_index,
    output logic [GHR_WIDTH-1:0]  ghr_out
);

    localparam int DEPTH = 1 << GHR_WIDTH;

    logic [1:0]           pht [DEPTH];
    logic [GHR_WIDTH-1:0] spec_ghr;
    logic [GHR_WIDTH-1:0] arch_ghr;
    logic [GHR_WIDTH-1:0] idx;
    logic                 upd_valid;
    logic                 upd_taken;
    logic [GHR_WIDTH-1:0] upd_index;
    logic [1:0]           ctr;
    logic [1:0]           ctr_next;
    logic                 unused_pc;

    assign unused_pc = ^{pc_in[ADDR_WIDTH-1:GHR_WIDTH+2], pc_in[1:0]};

    assign idx                 = pc_in[GHR_WIDTH+1:2] ^ spec_ghr;
    assign pht_index_out       = idx;
    assign is_branch_taken_out = pht[idx][1];
    assign ghr_out             = spec_ghr;

    // Training reads the counter one cycle after capture, so a
    // back-to-back update to the same index sees the prior write.
    assign ctr = pht[upd_index];

    always_comb begin
        ctr_next = ctr;
        if (upd_taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
        end else if (upd_valid) begin
            pht[upd_index] <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid <= 1'b0;
            upd_taken <= 1'b0;
            upd_index <= '0;
        end else begin
            upd_valid <= update_valid;
            upd_taken <= update_is_taken;
            upd_index <= update_pht_index;
        end
    end

    // Repair wins over a same-cycle lookup; that lookup is being flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else begin
            if (update_valid && update_mispredict)
                spec_ghr <= {arch_ghr[GHR_WIDTH-2:0], update_is_taken};
            else if (lookup_valid && !stall_pc)
                spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], is_branch_taken_out};
            if (update_valid)
                arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], update_is_taken};
        end
    end

endmodule
